// File: rtl/attribute_collector.sv
// Attribute collector: arms the XML attribute parser, gathers finished
// (type, value) pairs into a per-element record and hands the record to
// the layout stage over a valid/ready handshake when the element closes.
module attribute_collector #(
    parameter int unsigned TYPE_W  = 4,
    parameter int unsigned VAL_W   = 32,
    parameter int unsigned NUM_ATT = 11
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     elem_start,
    input  logic                     elem_end,
    input  logic                     attr_req,
    output logic                     att_enable,
    input  logic                     att_done,
    input  logic [TYPE_W-1:0]        att_type,
    input  logic [VAL_W-1:0]         att_value,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [NUM_ATT*VAL_W-1:0] rec_fields,
    output logic [NUM_ATT-1:0]       rec_mask,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic                     busy
);

    typedef enum logic [2:0] {StIdle, StOpen, StAttr, StRearm, StHold} state_e;

    localparam logic [1:0] ErrBadType  = 2'd1;
    localparam logic [1:0] ErrMidAttr  = 2'd2;
    localparam logic [1:0] ErrStartBsy = 2'd3;

    state_e                     state_q, state_d;
    logic [NUM_ATT*VAL_W-1:0]   fields_q, fields_d;
    logic [NUM_ATT-1:0]         mask_q, mask_d;
    logic                       err_q, err_d;
    logic [1:0]                 err_code_q, err_code_d;
    logic                       att_enable_q, rec_valid_q, busy_q;
    logic [NUM_ATT-1:0]         slot_sel;

    // One-hot slot decode of the parser type code; all-zero means an invalid type.
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < NUM_ATT; k++) begin
            slot_sel[k] = (att_type == TYPE_W'(k + 1));
        end
    end

    // Next-state, record update and error generation.
    always_comb begin
        state_d    = state_q;
        fields_d   = fields_q;
        mask_d     = mask_q;
        err_d      = 1'b0;
        err_code_d = 2'd0;
        unique case (state_q)
            StIdle: begin
                if (elem_start) begin
                    state_d  = StOpen;
                    fields_d = '0;
                    mask_d   = '0;
                end
            end
            StOpen: begin
                if (elem_start) begin
                    err_d      = 1'b1;
                    err_code_d = ErrStartBsy;
                    fields_d   = '0;
                    mask_d     = '0;
                end else if (elem_end) begin
                    state_d = StHold;
                end else if (attr_req) begin
                    state_d = StAttr;
                end
            end
            StAttr: begin
                if (elem_end && !att_done) begin
                    // Partial attribute is dropped; this error outranks a concurrent restart.
                    err_d      = 1'b1;
                    err_code_d = ErrMidAttr;
                    state_d    = StHold;
                end else if (elem_start) begin
                    err_d      = 1'b1;
                    err_code_d = ErrStartBsy;
                    fields_d   = '0;
                    mask_d     = '0;
                    state_d    = StOpen;
                end else if (att_done) begin
                    if (|slot_sel) begin
                        for (int k = 0; k < NUM_ATT; k++) begin
                            if (slot_sel[k]) begin
                                fields_d[k*VAL_W +: VAL_W] = att_value;
                                mask_d[k]                  = 1'b1;
                            end
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrBadType;
                    end
                    // Closing the element in the commit cycle skips the rearm gap.
                    state_d = elem_end ? StHold : StRearm;
                end
            end
            StRearm: begin
                if (elem_start) begin
                    err_d      = 1'b1;
                    err_code_d = ErrStartBsy;
                    fields_d   = '0;
                    mask_d     = '0;
                    state_d    = StOpen;
                end else if (elem_end) begin
                    state_d = StHold;
                end else begin
                    state_d = StOpen;
                end
            end
            StHold: begin
                // A new tag while a record is pending is flagged and dropped.
                if (elem_start) begin
                    err_d      = 1'b1;
                    err_code_d = ErrStartBsy;
                end
                if (rec_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, record and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            fields_q     <= '0;
            mask_q       <= '0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            att_enable_q <= 1'b0;
            rec_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fields_q     <= fields_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            att_enable_q <= (state_d == StAttr);
            rec_valid_q  <= (state_d == StHold);
            busy_q       <= (state_d != StIdle);
        end
    end

    assign att_enable = att_enable_q;
    assign rec_valid  = rec_valid_q;
    assign rec_fields = fields_q;
    assign rec_mask   = mask_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_attribute_collector.sv
// Bench for attribute_collector: directed vector table, hand-written reset
// sequence, then random stimulus against a reference model.
module tb_attribute_collector;

    localparam int unsigned TYPE_W  = 4;
    localparam int unsigned VAL_W   = 32;
    localparam int unsigned NUM_ATT = 11;

    // Control pulse encodings {elem_start, elem_end, attr_req, att_done}.
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] ES   = 4'b1000;
    localparam logic [3:0] EE   = 4'b0100;
    localparam logic [3:0] AR   = 4'b0010;
    localparam logic [3:0] DN   = 4'b0001;
    // Expected flags {att_enable, rec_valid, busy, err}.
    localparam logic [3:0] XEN  = 4'b1000;
    localparam logic [3:0] XV   = 4'b0100;
    localparam logic [3:0] XB   = 4'b0010;
    localparam logic [3:0] XE   = 4'b0001;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic elem_start = 1'b0, elem_end = 1'b0, attr_req = 1'b0, att_done = 1'b0;
    logic rec_ready = 1'b0;
    logic [TYPE_W-1:0] att_type = '0;
    logic [VAL_W-1:0] att_value = '0;
    logic att_enable, rec_valid, err, busy;
    logic [1:0] err_code;
    logic [NUM_ATT*VAL_W-1:0] rec_fields;
    logic [NUM_ATT-1:0] rec_mask;

    int total = 0;
    int bad = 0;

    attribute_collector #(.TYPE_W(TYPE_W), .VAL_W(VAL_W), .NUM_ATT(NUM_ATT)) dut (
        .clock(clock), .resetn(resetn), .elem_start(elem_start), .elem_end(elem_end),
        .attr_req(attr_req), .att_enable(att_enable), .att_done(att_done),
        .att_type(att_type), .att_value(att_value), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_fields(rec_fields), .rec_mask(rec_mask),
        .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  ctl;
        logic [3:0]  ty;
        logic [31:0] val;
        logic        rdy;
        logic [3:0]  ex;
        logic [1:0]  code;
        logic [10:0] mask;
        int          sk;
        logic [31:0] sv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [3:0] ty,
                                input logic [31:0] val, input logic rdy,
                                input logic [3:0] ex, input logic [1:0] code,
                                input logic [10:0] mask, input int sk,
                                input logic [31:0] sv);
        vec_t v;
        v.ctl = ctl; v.ty = ty; v.val = val; v.rdy = rdy; v.ex = ex;
        v.code = code; v.mask = mask; v.sk = sk; v.sv = sv;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_fields(input string name, input logic [NUM_ATT*VAL_W-1:0] act,
                                input logic [NUM_ATT*VAL_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int k);
        return rec_fields[(k-1)*VAL_W +: VAL_W];
    endfunction

    task automatic drive(input logic [3:0] ctl, input logic [3:0] ty,
                         input logic [31:0] val, input logic rdy);
        elem_start = ctl[3];
        elem_end   = ctl[2];
        attr_req   = ctl[1];
        att_done   = ctl[0];
        att_type   = ty;
        att_value  = val;
        rec_ready  = rdy;
    endtask

    task automatic tick(input logic [3:0] ctl, input logic [3:0] ty,
                        input logic [31:0] val, input logic rdy);
        drive(ctl, ty, val, rdy);
        @(posedge clock);
        #1;
    endtask

    // Reference model: element record plus the collector's phase.
    typedef enum {MIdle, MOpen, MAttr, MRearm, MHold} mphase_e;
    mphase_e m_ph;
    logic [31:0] m_slot [1:11];
    logic [10:0] m_mask;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic m_clear();
        for (int k = 1; k <= 11; k++) m_slot[k] = '0;
        m_mask = '0;
    endtask

    task automatic m_step(input logic es, input logic ee, input logic ar, input logic dn,
                          input logic [3:0] ty, input logic [31:0] val, input logic rdy);
        m_err = 1'b0;
        m_code = 2'd0;
        case (m_ph)
            MIdle: if (es) begin m_clear(); m_ph = MOpen; end
            MHold: begin
                if (es) begin m_err = 1'b1; m_code = 2'd3; end
                if (rdy) m_ph = MIdle;
            end
            default: begin
                if (m_ph == MAttr && ee && !dn) begin
                    m_err = 1'b1; m_code = 2'd2; m_ph = MHold;
                end else if (es) begin
                    m_err = 1'b1; m_code = 2'd3; m_clear(); m_ph = MOpen;
                end else if (m_ph == MAttr) begin
                    if (dn) begin
                        if (ty >= 4'd1 && ty <= 4'd11) begin
                            m_slot[ty] = val;
                            m_mask[ty-1] = 1'b1;
                        end else begin
                            m_err = 1'b1; m_code = 2'd1;
                        end
                        m_ph = ee ? MHold : MRearm;
                    end
                end else if (ee) begin
                    m_ph = MHold;
                end else if (m_ph == MOpen && ar) begin
                    m_ph = MAttr;
                end else if (m_ph == MRearm) begin
                    m_ph = MOpen;
                end
            end
        endcase
    endtask

    initial begin
        logic [NUM_ATT*VAL_W-1:0] exp_fields;
        logic [3:0] rctl;
        logic [3:0] rty;
        logic [31:0] rval;
        logic rrdy;

        // Reset state
        drive(NONE, 4'd0, 32'd0, 1'b0);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset att_enable", 64'(att_enable), 64'd0);
        check("reset rec_valid", 64'(rec_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset err_code", 64'(err_code), 64'd0);
        check("reset rec_mask", 64'(rec_mask), 64'd0);
        check_fields("reset rec_fields", rec_fields, '0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Single attribute, handshake, rearm gap
        vecs.push_back(mk(ES,   4'd0, 32'd0,   1'b0, XB,     2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0, 32'd0,   1'b0, XEN|XB, 2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd3, 32'd120, 1'b0, XB,     2'd0, 11'h004, 3, 32'd120));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,   1'b0, XB,     2'd0, 11'h004, 0, 32'd0));
        vecs.push_back(mk(EE,   4'd0, 32'd0,   1'b0, XV|XB,  2'd0, 11'h004, 0, 32'd0));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,   1'b1, 4'b0,   2'd0, 11'h004, 3, 32'd120));
        // Duplicate type overwrites, second type added
        vecs.push_back(mk(ES,   4'd0, 32'd0,        1'b0, XB,     2'd0, 11'h000, 3, 32'd0));
        vecs.push_back(mk(AR,   4'd0, 32'd0,        1'b0, XEN|XB, 2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd1, 32'hFF0000,   1'b0, XB,     2'd0, 11'h001, 1, 32'hFF0000));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,        1'b0, XB,     2'd0, 11'h001, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0, 32'd0,        1'b0, XEN|XB, 2'd0, 11'h001, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd1, 32'h00FF00,   1'b0, XB,     2'd0, 11'h001, 1, 32'h00FF00));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,        1'b0, XB,     2'd0, 11'h001, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0, 32'd0,        1'b0, XEN|XB, 2'd0, 11'h001, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd4, 32'd40,       1'b0, XB,     2'd0, 11'h009, 4, 32'd40));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,        1'b0, XB,     2'd0, 11'h009, 0, 32'd0));
        vecs.push_back(mk(EE,   4'd0, 32'd0,        1'b0, XV|XB,  2'd0, 11'h009, 1, 32'h00FF00));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,        1'b1, 4'b0,   2'd0, 11'h009, 4, 32'd40));
        // Bad type codes 0 and 14
        vecs.push_back(mk(ES,   4'd0,  32'd0, 1'b0, XB,     2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0,  32'd0, 1'b0, XEN|XB, 2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd0,  32'd5, 1'b0, XB|XE,  2'd1, 11'h000, 0, 32'd0));
        vecs.push_back(mk(NONE, 4'd0,  32'd0, 1'b0, XB,     2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0,  32'd0, 1'b0, XEN|XB, 2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd14, 32'd7, 1'b0, XB|XE,  2'd1, 11'h000, 0, 32'd0));
        vecs.push_back(mk(NONE, 4'd0,  32'd0, 1'b0, XB,     2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(EE,   4'd0,  32'd0, 1'b0, XV|XB,  2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(NONE, 4'd0,  32'd0, 1'b1, 4'b0,   2'd0, 11'h000, 0, 32'd0));
        // Close mid-attribute, then close in the commit cycle
        vecs.push_back(mk(ES,    4'd0, 32'd0,    1'b0, XB,       2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,    4'd0, 32'd0,    1'b0, XEN|XB,   2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,    4'd2, 32'h22,   1'b0, XB,       2'd0, 11'h002, 2, 32'h22));
        vecs.push_back(mk(NONE,  4'd0, 32'd0,    1'b0, XB,       2'd0, 11'h002, 0, 32'd0));
        vecs.push_back(mk(AR,    4'd0, 32'd0,    1'b0, XEN|XB,   2'd0, 11'h002, 0, 32'd0));
        vecs.push_back(mk(EE,    4'd5, 32'h55,   1'b0, XV|XB|XE, 2'd2, 11'h002, 5, 32'd0));
        vecs.push_back(mk(NONE,  4'd0, 32'd0,    1'b1, 4'b0,     2'd0, 11'h002, 0, 32'd0));
        vecs.push_back(mk(ES,    4'd0, 32'd0,    1'b0, XB,       2'd0, 11'h000, 2, 32'd0));
        vecs.push_back(mk(AR,    4'd0, 32'd0,    1'b0, XEN|XB,   2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(EE|DN, 4'd6, 32'h66,   1'b0, XV|XB,    2'd0, 11'h020, 6, 32'h66));
        vecs.push_back(mk(NONE,  4'd0, 32'd0,    1'b1, 4'b0,     2'd0, 11'h020, 6, 32'h66));
        // Restart inside ATTR, then elem_end beats attr_req in OPEN
        vecs.push_back(mk(ES,    4'd0, 32'd0, 1'b0, XB,     2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,    4'd0, 32'd0, 1'b0, XEN|XB, 2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,    4'd7, 32'd9, 1'b0, XB,     2'd0, 11'h040, 7, 32'd9));
        vecs.push_back(mk(NONE,  4'd0, 32'd0, 1'b0, XB,     2'd0, 11'h040, 0, 32'd0));
        vecs.push_back(mk(AR,    4'd0, 32'd0, 1'b0, XEN|XB, 2'd0, 11'h040, 0, 32'd0));
        vecs.push_back(mk(ES,    4'd0, 32'd0, 1'b0, XB|XE,  2'd3, 11'h000, 7, 32'd0));
        vecs.push_back(mk(EE|AR, 4'd0, 32'd0, 1'b0, XV|XB,  2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(NONE,  4'd0, 32'd0, 1'b1, 4'b0,   2'd0, 11'h000, 0, 32'd0));
        // elem_start while holding with rec_ready low
        vecs.push_back(mk(ES,   4'd0, 32'd0,  1'b0, XB,       2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(AR,   4'd0, 32'd0,  1'b0, XEN|XB,   2'd0, 11'h000, 0, 32'd0));
        vecs.push_back(mk(DN,   4'd8, 32'h88, 1'b0, XB,       2'd0, 11'h080, 8, 32'h88));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,  1'b0, XB,       2'd0, 11'h080, 0, 32'd0));
        vecs.push_back(mk(EE,   4'd0, 32'd0,  1'b0, XV|XB,    2'd0, 11'h080, 0, 32'd0));
        vecs.push_back(mk(ES,   4'd0, 32'd0,  1'b0, XV|XB|XE, 2'd3, 11'h080, 8, 32'h88));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(NONE, 4'd0, 32'd0, 1'b0, XV|XB, 2'd0, 11'h080, 8, 32'h88));
        vecs.push_back(mk(NONE, 4'd0, 32'd0,  1'b1, 4'b0,     2'd0, 11'h080, 8, 32'h88));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].ctl, vecs[i].ty, vecs[i].val, vecs[i].rdy);
            check($sformatf("v%0d att_enable", i), 64'(att_enable), 64'(vecs[i].ex[3]));
            check($sformatf("v%0d rec_valid", i), 64'(rec_valid), 64'(vecs[i].ex[2]));
            check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].ex[1]));
            check($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].ex[0]));
            if (vecs[i].ex[0])
                check($sformatf("v%0d err_code", i), 64'(err_code), 64'(vecs[i].code));
            check($sformatf("v%0d rec_mask", i), 64'(rec_mask), 64'(vecs[i].mask));
            if (vecs[i].sk != 0)
                check($sformatf("v%0d slot%0d", i, vecs[i].sk), 64'(slot(vecs[i].sk)),
                      64'(vecs[i].sv));
        end

        // Asynchronous reset between edges while an attribute is in flight
        tick(ES, 4'd0, 32'd0, 1'b0);
        tick(AR, 4'd0, 32'd0, 1'b0);
        tick(DN, 4'd2, 32'h5, 1'b0);
        tick(NONE, 4'd0, 32'd0, 1'b0);
        tick(AR, 4'd0, 32'd0, 1'b0);
        check("pre-reset att_enable", 64'(att_enable), 64'd1);
        check("pre-reset rec_mask", 64'(rec_mask), 64'h002);
        drive(NONE, 4'd0, 32'd0, 1'b0);
        #3 resetn = 1'b0;
        #1;
        check("async att_enable", 64'(att_enable), 64'd0);
        check("async rec_valid", 64'(rec_valid), 64'd0);
        check("async rec_mask", 64'(rec_mask), 64'd0);
        check("async busy", 64'(busy), 64'd0);
        #2 resetn = 1'b1;
        tick(ES, 4'd0, 32'd0, 1'b0);
        check("post-reset busy", 64'(busy), 64'd1);
        tick(AR, 4'd0, 32'd0, 1'b0);
        check("post-reset att_enable", 64'(att_enable), 64'd1);
        tick(DN, 4'd3, 32'h33, 1'b0);
        check("post-reset rec_mask", 64'(rec_mask), 64'h004);
        check("post-reset slot3", 64'(slot(3)), 64'h33);

        // Random stimulus against the model
        drive(NONE, 4'd0, 32'd0, 1'b0);
        resetn = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;
        m_ph = MIdle;
        m_clear();
        for (int c = 0; c < 3000; c++) begin
            rctl[3] = ($urandom_range(0, 11) == 0);
            rctl[2] = ($urandom_range(0, 7) == 0);
            rctl[1] = ($urandom_range(0, 2) == 0);
            rctl[0] = ($urandom_range(0, 1) == 0);
            rty  = 4'($urandom_range(0, 15));
            rval = $urandom;
            rrdy = ($urandom_range(0, 1) == 0);
            m_step(rctl[3], rctl[2], rctl[1], rctl[0], rty, rval, rrdy);
            tick(rctl, rty, rval, rrdy);
            for (int k = 1; k <= 11; k++) exp_fields[(k-1)*VAL_W +: VAL_W] = m_slot[k];
            check($sformatf("r%0d att_enable", c), 64'(att_enable), 64'(m_ph == MAttr));
            check($sformatf("r%0d rec_valid", c), 64'(rec_valid), 64'(m_ph == MHold));
            check($sformatf("r%0d busy", c), 64'(busy), 64'(m_ph != MIdle));
            check($sformatf("r%0d err", c), 64'(err), 64'(m_err));
            if (m_err) check($sformatf("r%0d err_code", c), 64'(err_code), 64'(m_code));
            check($sformatf("r%0d rec_mask", c), 64'(rec_mask), 64'(m_mask));
            check_fields($sformatf("r%0d rec_fields", c), rec_fields, exp_fields);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/attribute_collector.md
Name: attribute_collector

Overview:
- Sits directly downstream of the XML attribute parser. It arms the parser via `att_enable` and captures each finished (type, value) pair into a per-element attribute record.
- On tag close it presents the completed record to the layout stage over a valid/ready handshake.
- It also owns the parser's enable/reset sequencing between consecutive attributes.

Parameters:
- TYPE_W, 4, width of the attribute type code; codes per constants.v: ATT_COLOR..ATT_POSITION = 1..11, 0 = none.
- VAL_W, 32, width of one attribute value.
- NUM_ATT, 11, number of record slots; slot k holds type code k.

Ports:
- clock  in  1  global clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- elem_start  in  1  one-cycle pulse: a new element tag opened.
- elem_end  in  1  one-cycle pulse: element tag closed.
- attr_req  in  1  one-cycle pulse: an attribute name begins on the char stream.
- att_enable  out  1  drives the parser's state_enable (1 = run, 0 = reset).
- att_done  in  1  parser has_finished; level, stays high until att_enable drops.
- att_type  in  TYPE_W  parser out_type.
- att_value  in  VAL_W  parser out_value.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_fields  out  NUM_ATT*VAL_W  slot k at [(k-1)*VAL_W +: VAL_W].
- rec_mask  out  NUM_ATT  bit k-1 set = slot k written this element.
- err  out  1  one-cycle error pulse.
- err_code  out  2  1 = bad type, 2 = element closed mid-attribute, 3 = elem_start while busy; valid when err=1.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; att_enable=0, rec_valid=0, rec_fields=0, rec_mask=0, err=0, err_code=0, busy=0.
- States: IDLE, OPEN, ATTR, REARM, HOLD. All outputs are registered.
- IDLE (att_enable=0):
  - elem_start → OPEN; clear rec_fields and rec_mask on the same edge.
  - All other inputs are ignored.
- OPEN (att_enable=0):
  - attr_req → ATTR; att_enable=1 from the next cycle.
  - elem_end → HOLD; rec_valid=1 from the next cycle.
  - attr_req and elem_end together: elem_end wins.
- ATTR (att_enable=1):
  - When att_done=1 is sampled and att_type is in 1..NUM_ATT: write att_value to slot att_type, set its mask bit, → REARM. A duplicate type overwrites (last wins) with no error.
  - When att_done=1 and att_type is 0 or >NUM_ATT: nothing is written, err pulse with code 1, → REARM.
  - elem_end with att_done=0: the partial attribute is discarded, err pulse with code 2, → HOLD.
  - elem_end with att_done=1 in the same cycle: commit first, then → HOLD (REARM skipped).
  - attr_req is ignored.
- REARM: att_enable=0 for exactly one cycle, which resets the parser so it drops att_done. Then → OPEN.
  - elem_end in REARM → HOLD.
- HOLD (att_enable=0):
  - rec_valid=1; rec_fields and rec_mask are stable.
  - rec_valid & rec_ready → IDLE; rec_valid=0 next cycle, and fields are held until the next elem_start.
- elem_start in any state other than IDLE:
  - OPEN, ATTR, REARM: err pulse with code 3; the record is cleared and the state becomes OPEN with att_enable=0, abandoning the in-flight attribute.
  - HOLD: err pulse with code 3; the pulse is dropped and the record is kept.
- Latency:
  - att_done sampled → slot visible on rec_fields the next cycle.
  - elem_end → rec_valid the next cycle.
- Simultaneous errors in one cycle: code 2 takes priority over code 3, and code 3 over code 1.
- resetn asserted mid-operation forces IDLE immediately; a held record is lost.

Test Plan:
- elem_start; attr_req; att_done with type=ATT_WIDTH (3), value=120; elem_end; rec_ready=1 → rec_valid for 1 cycle; slot 3 = 120, rec_mask=0x004; att_enable low exactly 1 cycle after att_done.
- Two attributes: ATT_COLOR=0xFF0000, then ATT_COLOR=0x00FF00, then ATT_HEIGHT=40 → slot 1=0x00FF00, slot 4=40, rec_mask=0x009, err never asserted.
- att_done with att_type=0, then type=14 → two err pulses with code 1, rec_mask unchanged, FSM returns to OPEN each time.
- elem_end while in ATTR with att_done=0 → err code 2, HOLD, rec_mask excludes the pending type. Repeat with att_done=1 in the same cycle → value committed, no err.
- elem_start while in HOLD with rec_ready=0 for 5 cycles → err code 3, record unchanged, rec_valid held. Release rec_ready → IDLE.
- Assert resetn=0 between clock edges during ATTR → att_enable, rec_valid, rec_mask and busy go 0 without waiting for a clock edge. The next elem_start works normally.
